// File: rtl/bf2i_frame_sched.sv
// bf2i_frame_sched: frame scheduler and flow control for the BF2I stage.
// A sideband pipe (vld/sof/eof/idx) tracks the butterfly registers.
module bf2i_frame_sched #(
    parameter int N_POINT = 512,
    parameter int BUNDLE  = 16,
    parameter int BF_LAT  = 1,
    parameter int IDX_W   = $clog2(N_POINT / BUNDLE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    input  logic             flush,
    output logic             bf_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic [IDX_W-1:0] out_idx,
    output logic             frame_err,
    output logic [15:0]      frames_done,
    output logic             busy
);

    localparam int NB = N_POINT / BUNDLE;
    localparam logic [IDX_W-1:0] L_IDX = IDX_W'(NB - 1);
    localparam bit SINGLE = (NB == 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cnt_nxt;

    logic [BF_LAT-1:0] r_vld;
    logic [BF_LAT-1:0] r_sof;
    logic [BF_LAT-1:0] r_eof;
    logic [IDX_W-1:0]  r_idx [BF_LAT];

    logic        r_err;
    logic [15:0] r_done;

    logic             w_adv;
    logic             w_acc;
    logic             w_err;
    logic             w_ent_vld;
    logic             w_ent_sof;
    logic             w_ent_eof;
    logic [IDX_W-1:0] w_ent_idx;

    // A bubble in the output slot never blocks the pipe.
    assign w_adv    = !r_vld[BF_LAT-1] || out_ready;
    assign bf_en    = w_adv && !rst;
    assign in_ready = w_adv && !rst && !flush;
    assign w_acc    = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err       = 1'b0;
        w_ent_vld   = 1'b0;
        w_ent_sof   = 1'b0;
        w_ent_eof   = 1'b0;
        w_ent_idx   = '0;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_acc) begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_sof) begin
                        w_ent_vld = 1'b1;
                        w_ent_sof = 1'b1;
                        if (SINGLE) begin
                            w_ent_eof = 1'b1;
                        end else begin
                            w_cnt_nxt   = IDX_W'(1);
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_RUN: begin
                    w_ent_vld = 1'b1;
                    if (in_sof) begin
                        // Realign: truncated frame never gets an eof.
                        w_err     = 1'b1;
                        w_ent_sof = 1'b1;
                        w_cnt_nxt = IDX_W'(1);
                    end else begin
                        w_ent_idx = r_cnt;
                        if (r_cnt == L_IDX) begin
                            w_ent_eof   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_sof <= '0;
            r_eof <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                r_idx[i] <= '0;
            end
        end else if (flush) begin
            r_vld <= '0;
        end else if (bf_en) begin
            for (int i = BF_LAT - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_sof[i] <= r_sof[i-1];
                r_eof[i] <= r_eof[i-1];
                r_idx[i] <= r_idx[i-1];
            end
            r_vld[0] <= w_ent_vld;
            r_sof[0] <= w_ent_sof;
            r_eof[0] <= w_ent_eof;
            r_idx[0] <= w_ent_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= '0;
        end else if (out_valid && out_ready && out_eof) begin
            r_done <= r_done + 16'd1;
        end
    end

    assign out_valid   = r_vld[BF_LAT-1];
    assign out_sof     = r_vld[BF_LAT-1] && r_sof[BF_LAT-1];
    assign out_eof     = r_vld[BF_LAT-1] && r_eof[BF_LAT-1];
    assign out_idx     = r_idx[BF_LAT-1];
    assign frame_err   = r_err;
    assign frames_done = r_done;
    assign busy        = (r_state == S_RUN) || (|r_vld);

endmodule

// File: tb/tb_bf2i_frame_sched.sv
// tb_bf2i_frame_sched: scenario tasks checked against a frame-level model
// of the scheduler (position counter plus a queue of in-flight beats).
module tb_bf2i_frame_sched;

    localparam int FRAME = 32;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic        flush;
    logic        bf_en;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eof;
    logic [4:0]  out_idx;
    logic        frame_err;
    logic [15:0] frames_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit v;
        bit s;
        bit e;
        int idx;
    } beat_t;

    beat_t       m_pipe [LAT];
    bit          m_run;
    int          m_pos;
    bit          m_err;
    logic [15:0] m_done;

    bf2i_frame_sched dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .flush      (flush),
        .bf_en      (bf_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_idx    (out_idx),
        .frame_err  (frame_err),
        .frames_done(frames_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic bit exp_in_ready();
        beat_t o;
        o = m_pipe[LAT-1];
        return !rst && !flush && (!o.v || out_ready);
    endfunction

    function automatic bit exp_busy();
        bit b;
        b = m_run;
        for (int i = 0; i < LAT; i++) b = b | m_pipe[i].v;
        return b;
    endfunction

    // Frame-level behaviour: where the beat sits in its frame decides tags.
    function automatic void model_edge();
        beat_t o;
        beat_t ent;
        bit    adv;
        bit    acc;
        bit    err;
        if (rst) begin
            for (int i = 0; i < LAT; i++) m_pipe[i] = '{0, 0, 0, 0};
            m_run  = 0;
            m_pos  = 0;
            m_err  = 0;
            m_done = 0;
            return;
        end
        o   = m_pipe[LAT-1];
        adv = !o.v || out_ready;
        acc = in_valid && adv && !flush;
        err = 0;
        ent = '{0, 0, 0, 0};
        if (o.v && out_ready && o.e) m_done = m_done + 16'd1;
        if (flush) begin
            for (int i = 0; i < LAT; i++) m_pipe[i].v = 0;
            m_run = 0;
            m_pos = 0;
        end else begin
            if (acc) begin
                if (in_sof) begin
                    err   = m_run;
                    ent   = '{1, 1, 0, 0};
                    m_run = 1;
                    m_pos = 1;
                end else if (!m_run) begin
                    err = 1;
                end else begin
                    ent   = '{1, 0, m_pos == FRAME - 1, m_pos};
                    m_pos = m_pos + 1;
                    if (m_pos == FRAME) begin
                        m_run = 0;
                        m_pos = 0;
                    end
                end
            end
            if (adv) begin
                for (int i = LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
                m_pipe[0] = ent;
            end
        end
        m_err = err;
    endfunction

    task automatic drive(input bit v, input bit s, input bit f, input bit r);
        in_valid  = v;
        in_sof    = s;
        flush     = f;
        out_ready = r;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 0, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (in_ready !== 1'b0 || bf_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready_en in_ready=%b bf_en=%b exp=0/0", in_ready, bf_en);
            end
            checks++;
            if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0) begin
                failures++;
                $display("FAIL reset_out v=%b s=%b e=%b exp=0", out_valid, out_sof, out_eof);
            end
            checks++;
            if (out_idx !== 5'd0 || frame_err !== 1'b0 || busy !== 1'b0 || frames_done !== 16'd0) begin
                failures++;
                $display("FAIL reset_state idx=%0d err=%b busy=%b done=%0d exp=0", out_idx, frame_err, busy, frames_done);
            end
        end
        rst = 1'b0;
        drive(0, 0, 0, 1);
        checks++;
        if (in_ready !== 1'b1 || bf_en !== 1'b1) begin
            failures++;
            $display("FAIL release_ready in_ready=%b bf_en=%b exp=1/1", in_ready, bf_en);
        end
    endtask

    task automatic test_full_frame();
        logic [15:0] d0;
        bit          ev;
        d0 = m_done;
        for (int k = 0; k < FRAME + 2; k++) begin
            drive(k < FRAME, k == 0, 0, 1);
            ev = (k >= 1) && (k <= FRAME);
            checks++;
            if (out_valid !== ev || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_valid k=%0d out_valid=%b in_ready=%b exp=%b/1", k, out_valid, in_ready, ev);
            end
            if (ev) begin
                checks++;
                if (out_idx !== 5'(k - 1) || out_sof !== (k == 1) || out_eof !== (k == FRAME)) begin
                    failures++;
                    $display("FAIL full_tags k=%0d idx=%0d sof=%b eof=%b exp_idx=%0d", k, out_idx, out_sof, out_eof, k - 1);
                end
            end
            step();
        end
        checks++;
        if (frames_done !== d0 + 16'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done done=%0d busy=%b exp=%0d/0", frames_done, busy, d0 + 16'd1);
        end
    endtask

    task automatic test_backpressure();
        int    b;
        int    stalls;
        int    held;
        int    got[$];
        bit    r;
        bit    bad;
        beat_t o;
        b      = 0;
        stalls = 0;
        held   = 0;
        for (int c = 0; c < 80 && got.size() < FRAME; c++) begin
            o = m_pipe[LAT-1];
            r = 1;
            if (o.v && o.idx == 7 && stalls < 3) begin
                r = 0;
                stalls++;
            end
            drive(b < FRAME, b == 0, 0, r);
            if (out_valid === 1'b1 && out_idx === 5'd7) held++;
            if (!r) begin
                checks++;
                if (bf_en !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 5'd7) begin
                    failures++;
                    $display("FAIL bp_stall en=%b rdy=%b v=%b idx=%0d exp=0/0/1/7", bf_en, in_ready, out_valid, out_idx);
                end
            end
            if (out_valid === 1'b1 && out_ready) got.push_back(int'(out_idx));
            if (in_valid && exp_in_ready()) b++;
            step();
        end
        checks++;
        if (held != 4) begin
            failures++;
            $display("FAIL bp_hold cycles=%0d exp=4", held);
        end
        bad = (got.size() != FRAME);
        for (int i = 0; i < got.size(); i++) if (got[i] != i) bad = 1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_seq count=%0d exp=%0d (or out of order)", got.size(), FRAME);
        end
    endtask

    task automatic test_framing();
        logic [15:0] d0;
        int          pulses;
        int          eofs;
        int          got[$];
        bit          bad;
        for (int k = 0; k < 4; k++) begin
            drive(k < 2, 0, 0, 1);
            checks++;
            if (out_valid !== 1'b0 || frame_err !== (k == 1 || k == 2)) begin
                failures++;
                $display("FAIL stray k=%0d out_valid=%b frame_err=%b exp=0/%b", k, out_valid, frame_err, k == 1 || k == 2);
            end
            step();
        end
        d0     = m_done;
        pulses = 0;
        eofs   = 0;
        for (int k = 0; k < 16; k++) begin
            drive(k < 14, k == 0 || k == 10, 0, 1);
            checks++;
            if (out_valid !== m_pipe[LAT-1].v || frame_err !== m_err) begin
                failures++;
                $display("FAIL realign_cyc k=%0d v=%b err=%b exp=%b/%b", k, out_valid, frame_err, m_pipe[LAT-1].v, m_err);
            end
            if (frame_err === 1'b1) pulses++;
            if (out_eof === 1'b1) eofs++;
            if (out_valid === 1'b1) begin
                got.push_back(int'(out_idx));
                if (out_idx === 5'd0) begin
                    checks++;
                    if (out_sof !== 1'b1) begin
                        failures++;
                        $display("FAIL realign_sof k=%0d sof=%b exp=1", k, out_sof);
                    end
                end
            end
            step();
        end
        bad = (got.size() != 14);
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] != ((i < 10) ? i : i - 10)) bad = 1;
        end
        checks++;
        if (bad || pulses != 1 || eofs != 0) begin
            failures++;
            $display("FAIL realign_seq n=%0d pulses=%0d eofs=%0d exp=14/1/0", got.size(), pulses, eofs);
        end
        checks++;
        if (frames_done !== d0) begin
            failures++;
            $display("FAIL realign_done done=%0d exp=%0d", frames_done, d0);
        end
        drive(0, 0, 1, 1);
        step();
    endtask

    task automatic test_flush();
        logic [15:0] d0;
        int          b;
        int          got[$];
        bit          bad;
        for (int k = 0; k < 12; k++) begin
            drive(1, k == 0, 0, 1);
            step();
        end
        drive(1, 0, 1, 1);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready in_ready=%b exp=0", in_ready);
        end
        step();
        drive(0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear v=%b busy=%b err=%b exp=0/0/0", out_valid, busy, frame_err);
        end
        step();
        d0 = m_done;
        b  = 0;
        for (int c = 0; c < 60 && got.size() < FRAME; c++) begin
            drive(b < FRAME, b == 0, 0, 1);
            checks++;
            if (out_valid !== m_pipe[LAT-1].v) begin
                failures++;
                $display("FAIL flush_next_v c=%0d v=%b exp=%b", c, out_valid, m_pipe[LAT-1].v);
            end
            if (out_valid === 1'b1) got.push_back(int'(out_idx));
            if (exp_in_ready()) b++;
            step();
        end
        bad = (got.size() != FRAME);
        for (int i = 0; i < got.size(); i++) if (got[i] != i) bad = 1;
        checks++;
        if (bad || frames_done !== d0 + 16'd1) begin
            failures++;
            $display("FAIL flush_next_frame n=%0d done=%0d exp=%0d/%0d", got.size(), frames_done, FRAME, d0 + 16'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d0;
        int          b;
        int          errs;
        int          got[$];
        bit          v;
        bit          r;
        bit          bad;
        beat_t       o;
        d0   = m_done;
        b    = 0;
        errs = 0;
        for (int c = 0; c < 400 && got.size() < 2 * FRAME; c++) begin
            v = (b < 2 * FRAME) && (b == FRAME || $urandom_range(0, 3) != 0);
            r = $urandom_range(0, 4) != 0;
            drive(v, (b % FRAME) == 0, 0, r);
            o = m_pipe[LAT-1];
            checks++;
            if (in_ready !== exp_in_ready() || bf_en !== (!o.v || r) || out_valid !== o.v) begin
                failures++;
                $display("FAIL b2b_flow c=%0d rdy=%b en=%b v=%b exp=%b/%b/%b", c, in_ready, bf_en, out_valid, exp_in_ready(), !o.v || r, o.v);
            end
            if (o.v) begin
                checks++;
                if (out_idx !== 5'(o.idx) || out_sof !== o.s || out_eof !== o.e) begin
                    failures++;
                    $display("FAIL b2b_tags c=%0d idx=%0d sof=%b eof=%b exp=%0d/%b/%b", c, out_idx, out_sof, out_eof, o.idx, o.s, o.e);
                end
            end
            checks++;
            if (frame_err !== m_err || busy !== exp_busy() || frames_done !== m_done) begin
                failures++;
                $display("FAIL b2b_state c=%0d err=%b busy=%b done=%0d exp=%b/%b/%0d", c, frame_err, busy, frames_done, m_err, exp_busy(), m_done);
            end
            if (frame_err === 1'b1) errs++;
            if (out_valid === 1'b1 && r) got.push_back(int'(out_idx));
            if (v && exp_in_ready()) b++;
            step();
        end
        bad = (got.size() != 2 * FRAME);
        for (int i = 0; i < got.size(); i++) if (got[i] != (i % FRAME)) bad = 1;
        checks++;
        if (bad || errs != 0) begin
            failures++;
            $display("FAIL b2b_seq n=%0d errs=%0d exp=%0d/0", got.size(), errs, 2 * FRAME);
        end
        checks++;
        if (frames_done !== d0 + 16'd2) begin
            failures++;
            $display("FAIL b2b_done done=%0d exp=%0d", frames_done, d0 + 16'd2);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_framing();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
